// File: rtl/fd_pipe_skid.sv
// Fetch/decode pipeline register: 2-entry skid buffer with registered in_ready,
// flush, and a bank of saturating performance counters.

module fd_perf_ctr #(
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              inc,
   output logic [PERF_W-1:0] count
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                   count <= '0;
      else if (clear)                             count <= '0;
      else if (inc && (count != {PERF_W{1'b1}})) count <= count + 1'b1;
   end
endmodule

module fd_pipe_skid #(
   parameter int INSTR_W  = 32,
   parameter int PC_W     = 32,
   parameter int NUM_PERF = 6,
   parameter int PERF_W   = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [INSTR_W-1:0]               in_instr,
   input  logic [PC_W-1:0]                  in_pc,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [INSTR_W-1:0]               out_instr,
   output logic [PC_W-1:0]                  out_pc,
   input  logic                             flush,
   input  logic [NUM_PERF-4:0]              ext_event,
   input  logic                             perf_clear,
   output logic [NUM_PERF-1:0][PERF_W-1:0]  perf_count
);
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } entry_t;

   entry_t inEnt, mainQ, skidQ;
   logic   mainValid, skidValid, mainValidNxt, skidValidNxt;
   logic   loadMainIn, loadMainSkid, loadSkid;
   logic   acc, deq;

   assign inEnt     = '{instr: in_instr, pc: in_pc};
   assign acc       = in_valid && in_ready;
   assign deq       = mainValid && out_ready;
   assign out_valid = mainValid;
   assign out_instr = mainQ.instr;
   assign out_pc    = mainQ.pc;

   // Skid only fills while main is full, so main-empty/skid-full never occurs.
   always_comb begin
      mainValidNxt = mainValid;
      skidValidNxt = skidValid;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
      if (flush) begin
         mainValidNxt = 1'b0;
         skidValidNxt = 1'b0;
      end else if (!mainValid) begin
         if (acc) begin
            mainValidNxt = 1'b1;
            loadMainIn   = 1'b1;
         end
      end else if (deq) begin
         if (skidValid) begin
            loadMainSkid = 1'b1;
            skidValidNxt = 1'b0;
         end else if (acc) begin
            loadMainIn   = 1'b1;
         end else begin
            mainValidNxt = 1'b0;
         end
      end else if (acc) begin
         loadSkid     = 1'b1;
         skidValidNxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mainValid <= 1'b0;
         skidValid <= 1'b0;
         in_ready  <= 1'b1;
         mainQ     <= '0;
         skidQ     <= '0;
      end else begin
         mainValid <= mainValidNxt;
         skidValid <= skidValidNxt;
         in_ready  <= !skidValidNxt;
         if (loadMainIn)        mainQ <= inEnt;
         else if (loadMainSkid) mainQ <= skidQ;
         if (loadSkid)          skidQ <= inEnt;
      end
   end

   // Counter events: delivered, decode stall, flush, then external strobes.
   logic [NUM_PERF-1:0] perfEvent;
   assign perfEvent = {ext_event, flush, mainValid && !out_ready, deq};

   for (genvar g = 0; g < NUM_PERF; g++) begin : gCtr
      fd_perf_ctr #(.PERF_W(PERF_W)) uCtr (
         .clk   (clk),
         .rst   (rst),
         .clear (perf_clear),
         .inc   (perfEvent[g]),
         .count (perf_count[g])
      );
   end
endmodule

// File: tb/tb_fd_pipe_skid.sv
// Randomized bench for fd_pipe_skid against a queue-based model with
// saturating counters, plus directed scenarios with literal expectations.

module tb_fd_pipe_skid;
   localparam int NP = 6;
   localparam int PW = 4;
   localparam int SAT = (1 << PW) - 1;

   logic clk, rst, inValid, inReady, outValid, outReady, flush, perfClear;
   logic [31:0] inInstr, inPc, outInstr, outPc;
   logic [NP-4:0] extEvent;
   logic [NP-1:0][PW-1:0] perfCount;

   fd_pipe_skid #(.INSTR_W(32), .PC_W(32), .NUM_PERF(NP), .PERF_W(PW)) dut (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
      .in_instr(inInstr), .in_pc(inPc), .out_valid(outValid),
      .out_ready(outReady), .out_instr(outInstr), .out_pc(outPc),
      .flush(flush), .ext_event(extEvent), .perf_clear(perfClear),
      .perf_count(perfCount));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int nAssert = 0;
   int nFail   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the buffer is just an ordered list of at most two entries.
   typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
   ent_t q[$];
   int   cnt[NP];

   always @(negedge rst) begin
      q.delete();
      for (int i = 0; i < NP; i++) cnt[i] = 0;
   end

   always @(posedge clk) begin
      bit deqM, accM, ev;
      ent_t e;
      if (rst === 1'b1) begin
         deqM = (q.size() > 0) && outReady;
         accM = inValid && (q.size() < 2);
         for (int i = 0; i < NP; i++) begin
            if (i == 0)      ev = deqM;
            else if (i == 1) ev = (q.size() > 0) && !outReady;
            else if (i == 2) ev = flush;
            else             ev = extEvent[i-3];
            if (perfClear)             cnt[i] = 0;
            else if (ev && cnt[i] < SAT) cnt[i] = cnt[i] + 1;
         end
         if (flush) q.delete();
         else begin
            if (deqM) void'(q.pop_front());
            if (accM) begin
               e.instr = inInstr;
               e.pc    = inPc;
               q.push_back(e);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [NP-1:0][PW-1:0] expPerf;
      for (int i = 0; i < NP; i++) expPerf[i] = PW'(cnt[i]);
      check("out_valid", outValid, q.size() > 0);
      check("in_ready", inReady, q.size() < 2);
      if (q.size() > 0) begin
         check("out_instr", outInstr, q[0].instr);
         check("out_pc", outPc, q[0].pc);
      end
      check("perf_count", perfCount, expPerf);
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic offer(input logic [31:0] pc);
      inValid = 1'b1;
      inPc    = pc;
      inInstr = $urandom;
   endtask

   initial begin
      rst = 1'b0; inValid = 1'b0; inInstr = '0; inPc = '0; outReady = 1'b0;
      flush = 1'b0; extEvent = '0; perfClear = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      check("rst out_valid", outValid, 0);
      check("rst in_ready", inReady, 1);
      check("rst out_pc", outPc, 0);
      check("rst out_instr", outInstr, 0);
      check("rst perf", perfCount, 0);

      // streaming at full rate
      outReady = 1'b1;
      offer(32'h00); step(); check("stream pc0", outPc, 32'h00);
      offer(32'h04); step(); check("stream pc1", outPc, 32'h04);
      check("stream in_ready", inReady, 1);
      offer(32'h08); step(); check("stream pc2", outPc, 32'h08);
      inValid = 1'b0; step();
      check("stream drained", outValid, 0);
      check("stream delivered", perfCount[0], 3);

      // stall fill
      offer(32'h10); step(); check("fill main", outPc, 32'h10);
      outReady = 1'b0;
      offer(32'h14); step();
      check("fill in_ready", inReady, 0);
      check("fill hold pc", outPc, 32'h10);
      offer(32'h18); step();
      check("fill hold pc2", outPc, 32'h10);
      check("fill stalls", perfCount[1], 2);

      // stall release, fetch keeps offering 0x18
      outReady = 1'b1; step();
      check("release pc14", outPc, 32'h14);
      check("release in_ready", inReady, 1);
      step();
      check("release pc18", outPc, 32'h18);
      inValid = 1'b0; step();
      check("release drained", outValid, 0);
      check("release delivered", perfCount[0], 6);

      // flush with full buffer
      perfClear = 1'b1; offer(32'h20); step();
      perfClear = 1'b0; outReady = 1'b0; offer(32'h24); step();
      check("flush pre skid", inReady, 0);
      flush = 1'b1; offer(32'h28); step();
      check("flush out_valid", outValid, 0);
      check("flush in_ready", inReady, 1);
      check("flush count", perfCount[2], 1);
      flush = 1'b0; inValid = 1'b0; step();
      check("flush dropped", outValid, 0);

      // saturation then clear
      extEvent = 3'b001;
      repeat (20) step();
      check("sat perf3", perfCount[3], 15);
      perfClear = 1'b1; step();
      check("clear perf3", perfCount[3], 0);
      perfClear = 1'b0; extEvent = '0;

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         inValid   = ($urandom_range(0, 9) < 7);
         inInstr   = $urandom;
         inPc      = $urandom;
         outReady  = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 29) == 0);
         perfClear = ($urandom_range(0, 99) == 0);
         extEvent  = 3'($urandom);
         step();
      end

      // async reset with a full buffer and live counters
      flush = 1'b0; perfClear = 1'b0; outReady = 1'b0; extEvent = '1;
      offer(32'h30); step();
      offer(32'h34); step();
      check("pre-reset full", inReady, 0);
      inValid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("async out_valid", outValid, 0);
      check("async in_ready", inReady, 1);
      check("async perf", perfCount, 0);
      check("async out_pc", outPc, 0);
      @(negedge clk);
      rst = 1'b1; extEvent = '0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end
endmodule
